// File: rtl/minmax_tracker.sv
// -----------------------------------------------------------------------------
// minmax_tracker
//
// Purpose:
//   Tracks the largest and smallest unsigned sample in a window of win_len
//   samples. A window starts with the first sample accepted in IDLE. It
//   closes when the number of accepted samples reaches the window length
//   latched at that first sample. When the window closes, the block spends
//   one cycle in DONE. During that cycle out_valid pulses and in_ready is 0.
//   Results then hold until the next window's first accepted sample.
//
// Optional feature:
//   Define MINMAX_TIES_EN to add the ties output. ties counts accepted
//   samples equal to the running maximum. It restarts at 0 whenever the
//   maximum increases.
//
// Handshake:
//   A sample transfers on a rising edge where in_valid && in_ready. in_valid
//   may be held high while in_ready is 0. In that case the sample is not
//   consumed and must be presented again.
//
// Ports:
//   clk        sole clock, rising edge
//   n_rst      asynchronous active-low reset
//   clear      synchronous flush of the current window, wins over a sample
//   in_valid   in_data carries a sample this cycle
//   in_ready   block can accept a sample this cycle (0 only in DONE)
//   in_data    unsigned sample, DATA_W bits
//   win_len    samples per window, 0 treated as 1, sampled at first sample
//   max_out    largest sample of the current/last window
//   min_out    smallest sample of the current/last window
//   count      samples accepted in the current window
//   out_valid  one-cycle pulse, window result final
//   ties       samples equal to the running max (MINMAX_TIES_EN only)
//   fsm_state  current FSM state for observation (IDLE=0, ACCUM=1, DONE=2)
// -----------------------------------------------------------------------------
module minmax_tracker #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CNT_W-1:0]  win_len,
   output logic [DATA_W-1:0] max_out,
   output logic [DATA_W-1:0] min_out,
   output logic [CNT_W-1:0]  count,
   output logic              out_valid,
`ifdef MINMAX_TIES_EN
   output logic [CNT_W-1:0]  ties,
`endif
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  first_len;
   logic [CNT_W-1:0]  count_inc;
   logic              accept;

   // A requested length of 0 means a single-sample window.
   assign first_len = (win_len == '0) ? CNT_W'(1) : win_len;
   assign count_inc = count + CNT_W'(1);
   assign accept    = in_valid && in_ready;

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and state-decoded outputs
   always_comb begin
      state_next = state;
      in_ready   = 1'b1;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = (first_len == CNT_W'(1)) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            // Close the window on the edge where count reaches the latched length.
            if (accept && (count_inc == len_q)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            in_ready   = 1'b0;
            out_valid  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (clear) begin
         state_next = IDLE;
      end
   end

   assign fsm_state = state;

   // Datapath. accept implies IDLE or ACCUM, so the else-branch is ACCUM.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         max_out <= '0;
         min_out <= '0;
         count   <= '0;
         len_q   <= '0;
`ifdef MINMAX_TIES_EN
         ties    <= '0;
`endif
      end else if (clear) begin
         max_out <= '0;
         min_out <= '0;
         count   <= '0;
`ifdef MINMAX_TIES_EN
         ties    <= '0;
`endif
      end else if (accept) begin
         if (state == IDLE) begin
            max_out <= in_data;
            min_out <= in_data;
            count   <= CNT_W'(1);
            len_q   <= first_len;
`ifdef MINMAX_TIES_EN
            ties    <= '0;
`endif
         end else begin
            if (in_data > max_out) begin
               max_out <= in_data;
            end
            if (in_data < min_out) begin
               min_out <= in_data;
            end
            count <= count_inc;
`ifdef MINMAX_TIES_EN
            if (in_data > max_out) begin
               ties <= '0;
            end else if (in_data == max_out) begin
               ties <= ties + CNT_W'(1);
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_minmax_tracker.sv
// -----------------------------------------------------------------------------
// tb_minmax_tracker
//
// Purpose:
//   Directed, table-driven bench for minmax_tracker. Each table row is one
//   clock cycle. It holds the inputs, the in_ready expected before the edge,
//   and the outputs expected after the edge. Hand-written sequences cover
//   the initial reset, the asynchronous mid-window reset and the out_valid
//   pulse count.
//
// Ports: none (top-level bench).
// Optional: MINMAX_TIES_EN enables the ties connection and its checks.
// -----------------------------------------------------------------------------
module tb_minmax_tracker;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 8;

   logic              clk;
   logic              n_rst;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CNT_W-1:0]  win_len;
   logic [DATA_W-1:0] max_out;
   logic [DATA_W-1:0] min_out;
   logic [CNT_W-1:0]  count;
   logic              out_valid;
   logic [1:0]        fsm_state;
`ifdef MINMAX_TIES_EN
   logic [CNT_W-1:0]  ties;
`endif

   int checks;
   int errors;

   typedef struct {
      logic              clr;
      logic              vld;
      logic [DATA_W-1:0] data;
      logic [CNT_W-1:0]  len;
      logic              e_ready;
      logic              e_valid;
      logic [DATA_W-1:0] e_max;
      logic [DATA_W-1:0] e_min;
      logic [CNT_W-1:0]  e_cnt;
      logic [CNT_W-1:0]  e_ties;
   } vec_t;

   vec_t vecs[$];

   minmax_tracker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .win_len   (win_len),
      .max_out   (max_out),
      .min_out   (min_out),
      .count     (count),
      .out_valid (out_valid),
`ifdef MINMAX_TIES_EN
      .ties      (ties),
`endif
      .fsm_state (fsm_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one value and report a mismatch
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input logic e_valid, input logic [DATA_W-1:0] e_max,
                             input logic [DATA_W-1:0] e_min, input logic [CNT_W-1:0] e_cnt,
                             input logic [CNT_W-1:0] e_ties);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
      check({tag, ".max_out"},   32'(max_out),   32'(e_max));
      check({tag, ".min_out"},   32'(min_out),   32'(e_min));
      check({tag, ".count"},     32'(count),     32'(e_cnt));
`ifdef MINMAX_TIES_EN
      check({tag, ".ties"},      32'(ties),      32'(e_ties));
`else
      if (e_ties != e_ties) checks++;
`endif
   endtask

   function automatic vec_t mk(input logic clr, input logic vld, input logic [DATA_W-1:0] data,
                               input logic [CNT_W-1:0] len, input logic e_ready, input logic e_valid,
                               input logic [DATA_W-1:0] e_max, input logic [DATA_W-1:0] e_min,
                               input logic [CNT_W-1:0] e_cnt, input logic [CNT_W-1:0] e_ties);
      vec_t v;
      v.clr = clr; v.vld = vld; v.data = data; v.len = len;
      v.e_ready = e_ready; v.e_valid = e_valid;
      v.e_max = e_max; v.e_min = e_min; v.e_cnt = e_cnt; v.e_ties = e_ties;
      return v;
   endfunction

   // Drive one cycle at the falling edge, check in_ready before the rising
   // edge and the registered outputs just after it.
   task automatic apply(input string tag, input vec_t v);
      @(negedge clk);
      clear    = v.clr;
      in_valid = v.vld;
      in_data  = v.data;
      win_len  = v.len;
      #1;
      check({tag, ".in_ready"}, 32'(in_ready), 32'(v.e_ready));
      @(posedge clk);
      #1;
      check_outs(tag, v.e_valid, v.e_max, v.e_min, v.e_cnt, v.e_ties);
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] len);
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      win_len  = len;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      int pulses;
      checks   = 0;
      errors   = 0;
      n_rst    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      win_len  = '0;

      // Reset state
      #12;
      check("reset.in_ready", 32'(in_ready), 32'd1);
      check_outs("reset", 1'b0, 16'h0, 16'h0, 8'd0, 8'd0);
      @(negedge clk);
      n_rst = 1'b1;

      // clr vld data len | ready valid max min cnt ties
      // Basic window, len 4: 5,9,2,9
      vecs.push_back(mk(0, 1, 16'd5,    8'd4, 1, 0, 16'd5,    16'd5,    8'd1, 8'd0));
      vecs.push_back(mk(0, 1, 16'd9,    8'd4, 1, 0, 16'd9,    16'd5,    8'd2, 8'd0));
      vecs.push_back(mk(0, 1, 16'd2,    8'd4, 1, 0, 16'd9,    16'd2,    8'd3, 8'd0));
      vecs.push_back(mk(0, 1, 16'd9,    8'd4, 1, 1, 16'd9,    16'd2,    8'd4, 8'd1));
      vecs.push_back(mk(0, 0, 16'd0,    8'd4, 0, 0, 16'd9,    16'd2,    8'd4, 8'd1));
      // Length 0 means 1
      vecs.push_back(mk(0, 1, 16'hFFFF, 8'd0, 1, 1, 16'hFFFF, 16'hFFFF, 8'd1, 8'd0));
      vecs.push_back(mk(0, 0, 16'd0,    8'd0, 0, 0, 16'hFFFF, 16'hFFFF, 8'd1, 8'd0));
      // Backpressure, len 2, in_valid held: 3,7,8 (8 stalled in DONE)
      vecs.push_back(mk(0, 1, 16'd3,    8'd2, 1, 0, 16'd3,    16'd3,    8'd1, 8'd0));
      vecs.push_back(mk(0, 1, 16'd7,    8'd2, 1, 1, 16'd7,    16'd3,    8'd2, 8'd0));
      vecs.push_back(mk(0, 1, 16'd8,    8'd2, 0, 0, 16'd7,    16'd3,    8'd2, 8'd0));
      vecs.push_back(mk(0, 1, 16'd8,    8'd2, 1, 0, 16'd8,    16'd8,    8'd1, 8'd0));
      vecs.push_back(mk(0, 1, 16'd1,    8'd2, 1, 1, 16'd8,    16'd1,    8'd2, 8'd0));
      vecs.push_back(mk(0, 0, 16'd0,    8'd2, 0, 0, 16'd8,    16'd1,    8'd2, 8'd0));
      // Clear overrides a simultaneous sample
      vecs.push_back(mk(0, 1, 16'd1,    8'd4, 1, 0, 16'd1,    16'd1,    8'd1, 8'd0));
      vecs.push_back(mk(0, 1, 16'd2,    8'd4, 1, 0, 16'd2,    16'd1,    8'd2, 8'd0));
      vecs.push_back(mk(1, 1, 16'h0010, 8'd4, 1, 0, 16'd0,    16'd0,    8'd0, 8'd0));
      vecs.push_back(mk(0, 0, 16'd0,    8'd4, 1, 0, 16'd0,    16'd0,    8'd0, 8'd0));
      // Gaps, len 3, win_len changed mid-window is ignored
      vecs.push_back(mk(0, 1, 16'h8000, 8'd3, 1, 0, 16'h8000, 16'h8000, 8'd1, 8'd0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 0, 16'd0, 8'd1, 1, 0, 16'h8000, 16'h8000, 8'd1, 8'd0));
      vecs.push_back(mk(0, 1, 16'h0001, 8'd1, 1, 0, 16'h8000, 16'h0001, 8'd2, 8'd0));
      vecs.push_back(mk(0, 1, 16'h7FFF, 8'd1, 1, 1, 16'h8000, 16'h0001, 8'd3, 8'd0));
      vecs.push_back(mk(0, 0, 16'd0,    8'd1, 0, 0, 16'h8000, 16'h0001, 8'd3, 8'd0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply($sformatf("vec%0d", i), vecs[i]);
      end

      // Asynchronous reset mid-window: two of four samples, then n_rst low
      send(16'd6, 8'd4);
      send(16'd3, 8'd4);
      @(negedge clk);
      #2;
      n_rst = 1'b0;
      #1;
      check_outs("async_rst", 1'b0, 16'h0, 16'h0, 8'd0, 8'd0);
      check("async_rst.state", 32'(fsm_state), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;

      // Next window 4,4,4,4, counting out_valid pulses over a bounded span
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         send(16'd4, 8'd4);
         if (out_valid) pulses++;
      end
      check_outs("equal4", 1'b1, 16'd4, 16'd4, 8'd4, 8'd3);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) pulses++;
      end
      check("equal4.pulses", 32'(pulses), 32'd1);
      check("equal4.hold_max", 32'(max_out), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
